// File: rtl/mod_bus_master_pkg.sv
// Shared definitions for the PLP data-bus initiator: FSM state encodings,
// bus read/write codes and the default byte stride between burst beats.
package mod_bus_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic BUS_RW_READ  = 1'b0;
  localparam logic BUS_RW_WRITE = 1'b1;

  localparam int unsigned ADDR_STRIDE_DEFAULT = 4;

endpackage

// File: rtl/mod_bus_master.sv
// mod_bus_master: initiator on the PLP data bus. Converts valid/ready word
// commands into single-cycle bus accesses (de/addr/rw/wdata) and returns one
// valid/ready response per beat (read data, or 0 for write acks).
// Optional feature macro: MOD_BUS_MASTER_BURST_EN (cmd_len+1 beats at
// incrementing addresses; otherwise every command is a single beat).
// Ports:
//   clk, rst (async, active-low)
//   cmd_valid/cmd_ready/cmd_rw/cmd_addr/cmd_wdata/cmd_len : command port
//   rsp_valid/rsp_ready/rsp_rdata/rsp_last                : response port
//   bus_de/bus_addr/bus_rw/bus_wdata/bus_rdata            : data bus
module mod_bus_master
  import mod_bus_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned ADDR_STRIDE = ADDR_STRIDE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last,
  output logic              bus_de,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_e              r_state,     w_state_nxt;
  logic                r_rw,        w_rw_nxt;
  logic                r_cmd_ready, w_cmd_ready_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                r_rsp_last,  w_rsp_last_nxt;
  logic                r_bus_de,    w_bus_de_nxt;
  logic [ADDR_W-1:0]   r_bus_addr,  w_bus_addr_nxt;
  logic                r_bus_rw,    w_bus_rw_nxt;
  logic [DATA_W-1:0]   r_bus_wdata, w_bus_wdata_nxt;
  logic                w_last_beat;

`ifdef MOD_BUS_MASTER_BURST_EN
  // Burst context: current beat address, fill data and remaining beats.
  logic [ADDR_W-1:0]   r_addr,      w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata,     w_wdata_nxt;
  logic [LEN_W-1:0]    r_beats,     w_beats_nxt;
  logic [ADDR_W-1:0]   w_addr_inc;

  // Increment wraps naturally modulo 2^ADDR_W.
  assign w_addr_inc  = r_addr + ADDR_W'(ADDR_STRIDE);
  assign w_last_beat = (r_beats == '0);
`else
  logic                w_unused_len;

  assign w_unused_len = ^cmd_len;
  assign w_last_beat  = 1'b1;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_rw_nxt        = r_rw;
    w_cmd_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_last_nxt  = 1'b0;
    w_bus_de_nxt    = 1'b0;
    w_bus_addr_nxt  = '0;
    w_bus_rw_nxt    = BUS_RW_READ;
    w_bus_wdata_nxt = '0;
`ifdef MOD_BUS_MASTER_BURST_EN
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_beats_nxt     = r_beats;
`endif
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_state_nxt     = ST_ACCESS;
          w_rw_nxt        = cmd_rw;
          w_bus_de_nxt    = 1'b1;
          w_bus_addr_nxt  = cmd_addr;
          w_bus_rw_nxt    = cmd_rw;
          w_bus_wdata_nxt = cmd_wdata;
`ifdef MOD_BUS_MASTER_BURST_EN
          w_addr_nxt      = cmd_addr;
          w_wdata_nxt     = cmd_wdata;
          w_beats_nxt     = cmd_len;
`endif
        end else begin
          w_cmd_ready_nxt = 1'b1;
        end
      end
      ST_ACCESS: begin
        // Responder dout is valid while de is high; capture it on this edge.
        w_state_nxt     = ST_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_rdata_nxt = (r_rw == BUS_RW_WRITE) ? '0 : bus_rdata;
        w_rsp_last_nxt  = w_last_beat;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (w_last_beat) begin
            w_state_nxt     = ST_IDLE;
            w_cmd_ready_nxt = 1'b1;
          end else begin
`ifdef MOD_BUS_MASTER_BURST_EN
            w_state_nxt     = ST_ACCESS;
            w_beats_nxt     = r_beats - LEN_W'(1);
            w_addr_nxt      = w_addr_inc;
            w_bus_de_nxt    = 1'b1;
            w_bus_addr_nxt  = w_addr_inc;
            w_bus_rw_nxt    = r_rw;
            w_bus_wdata_nxt = r_wdata;
`endif
          end
        end else begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_last_nxt  = r_rsp_last;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rw        <= BUS_RW_READ;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_last  <= 1'b0;
      r_bus_de    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_rw    <= BUS_RW_READ;
      r_bus_wdata <= '0;
`ifdef MOD_BUS_MASTER_BURST_EN
      r_addr      <= '0;
      r_wdata     <= '0;
      r_beats     <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_rw        <= w_rw_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_last  <= w_rsp_last_nxt;
      r_bus_de    <= w_bus_de_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_rw    <= w_bus_rw_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
`ifdef MOD_BUS_MASTER_BURST_EN
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_beats     <= w_beats_nxt;
`endif
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_last  = r_rsp_last;
  assign bus_de    = r_bus_de;
  assign bus_addr  = r_bus_addr;
  assign bus_rw    = r_bus_rw;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mod_bus_master.sv
// Directed self-checking bench for mod_bus_master with a 4-word GPIO-style
// responder (writes on negedge, combinational dout while de is high).
// Honours MOD_BUS_MASTER_BURST_EN to select the burst or single-beat test.
module tb_mod_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [7:0]  cmd_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_last;
  logic        bus_de;
  logic [31:0] bus_addr;
  logic        bus_rw;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  logic [31:0] mem [4];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mod_bus_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_len   (cmd_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_last  (rsp_last),
    .bus_de    (bus_de),
    .bus_addr  (bus_addr),
    .bus_rw    (bus_rw),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  // Responder model.
  always @(negedge clk) begin
    if (bus_de && bus_rw) mem[bus_addr[3:2]] <= bus_wdata;
  end
  assign bus_rdata = bus_de ? mem[bus_addr[3:2]] : 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_len   = len;
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_len = '0; rsp_ready = 1'b1;
    #3;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_last, bus_de, bus_rw} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b exp 00000",
               {cmd_ready, rsp_valid, rsp_last, bus_de, bus_rw});
    end
    n_checks++;
    if ((bus_addr | bus_wdata | rsp_rdata) !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h wdata %h rdata %h exp 0",
               bus_addr, bus_wdata, rsp_rdata);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_after: got %b exp 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    issue(1'b1, 32'h4, 32'hA5, 8'd0);
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if ({bus_de, bus_rw, cmd_ready} !== 3'b110 || bus_addr !== 32'h4 || bus_wdata !== 32'hA5) begin
      n_fail++;
      $display("FAIL write_access: de/rw/rdy %b addr %h wdata %h exp 110 4 a5",
               {bus_de, bus_rw, cmd_ready}, bus_addr, bus_wdata);
    end
    tick();
    n_checks++;
    if ({bus_de, rsp_valid, rsp_last} !== 3'b011 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL write_resp: de/v/l %b rdata %h exp 011 0",
               {bus_de, rsp_valid, rsp_last}, rsp_rdata);
    end
    n_checks++;
    if (mem[1] !== 32'hA5) begin
      n_fail++; $display("FAIL write_mem: got %h exp a5", mem[1]);
    end
    tick();
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL write_done: v/rdy %b exp 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_read();
    logic [31:0] addrs [2];
    logic [31:0] exps  [2];
    addrs[0] = 32'h0; exps[0] = 32'h0000FF00;
    addrs[1] = 32'h4; exps[1] = 32'hA5;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, addrs[i], 32'hDEAD, 8'd0);
      tick();
      cmd_valid = 1'b0;
      n_checks++;
      if ({bus_de, bus_rw} !== 2'b10 || bus_addr !== addrs[i] || bus_wdata !== 32'hDEAD) begin
        n_fail++;
        $display("FAIL read_access[%0d]: de/rw %b addr %h wdata %h",
                 i, {bus_de, bus_rw}, bus_addr, bus_wdata);
      end
      tick();
      n_checks++;
      if ({rsp_valid, rsp_last} !== 2'b11 || rsp_rdata !== exps[i]) begin
        n_fail++;
        $display("FAIL read_resp[%0d]: v/l %b rdata %h exp 11 %h",
                 i, {rsp_valid, rsp_last}, rsp_rdata, exps[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0, 32'h0, 8'd0);
    tick();
    // A second command waits during the stall and must be taken afterwards.
    issue(1'b1, 32'h8, 32'h5A, 8'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rsp_valid, rsp_last, cmd_ready, bus_de} !== 4'b1100 || rsp_rdata !== 32'h0000FF00) begin
        n_fail++;
        $display("FAIL stall[%0d]: v/l/rdy/de %b rdata %h exp 1100 ff00",
                 i, {rsp_valid, rsp_last, cmd_ready, bus_de}, rsp_rdata);
      end
      if (i < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if ({cmd_ready, rsp_valid, bus_de} !== 3'b100) begin
      n_fail++;
      $display("FAIL stall_release: rdy/v/de %b exp 100", {cmd_ready, rsp_valid, bus_de});
    end
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if ({bus_de, bus_rw} !== 2'b11 || bus_addr !== 32'h8 || bus_wdata !== 32'h5A) begin
      n_fail++;
      $display("FAIL pending_cmd: de/rw %b addr %h wdata %h exp 11 8 5a",
               {bus_de, bus_rw}, bus_addr, bus_wdata);
    end
    tick();
    n_checks++;
    if (mem[2] !== 32'h5A || rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL pending_resp: mem %h v %b exp 5a 1", mem[2], rsp_valid);
    end
    tick();
  endtask

`ifdef MOD_BUS_MASTER_BURST_EN
  task automatic test_burst();
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    addrs[0] = 32'hFFFFFFF8; exps[0] = 32'h5A;
    addrs[1] = 32'hFFFFFFFC; exps[1] = 32'h22;
    addrs[2] = 32'h00000000; exps[2] = 32'h0000FF00;
    issue(1'b0, 32'hFFFFFFF8, 32'h0, 8'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmd_valid = 1'b0;
      n_checks++;
      if (bus_de !== 1'b1 || bus_addr !== addrs[i] || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL burst_addr[%0d]: de %b addr %h exp 1 %h", i, bus_de, bus_addr, addrs[i]);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exps[i] || rsp_last !== (i == 2)) begin
        n_fail++;
        $display("FAIL burst_resp[%0d]: v %b rdata %h last %b exp %h", i, rsp_valid,
                 rsp_rdata, rsp_last, exps[i]);
      end
    end
    tick();
    n_checks++;
    if ({cmd_ready, bus_de, rsp_valid} !== 3'b100) begin
      n_fail++; $display("FAIL burst_done: rdy/de/v %b exp 100", {cmd_ready, bus_de, rsp_valid});
    end
  endtask
`else
  task automatic test_len_ignored();
    issue(1'b0, 32'hFFFFFFF8, 32'h0, 8'd2);
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (bus_de !== 1'b1 || bus_addr !== 32'hFFFFFFF8) begin
      n_fail++; $display("FAIL single_addr: de %b addr %h exp 1 fffffff8", bus_de, bus_addr);
    end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_last} !== 2'b11 || rsp_rdata !== 32'h5A) begin
      n_fail++;
      $display("FAIL single_resp: v/l %b rdata %h exp 11 5a", {rsp_valid, rsp_last}, rsp_rdata);
    end
    tick();
    n_checks++;
    if ({cmd_ready, bus_de, rsp_valid} !== 3'b100) begin
      n_fail++; $display("FAIL single_done: rdy/de/v %b exp 100", {cmd_ready, bus_de, rsp_valid});
    end
    tick();
    n_checks++;
    if ({bus_de, rsp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL single_no_extra: de/v %b exp 00", {bus_de, rsp_valid});
    end
  endtask
`endif

  task automatic test_reset_mid();
    issue(1'b0, 32'h0, 32'h0, 8'd3);
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (bus_de !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre: de %b exp 1", bus_de);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus_de, rsp_valid, rsp_last, cmd_ready, bus_rw} !== 5'b0 || bus_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_now: de/v/l/rdy/rw %b addr %h exp 0",
               {bus_de, rsp_valid, rsp_last, cmd_ready, bus_rw}, bus_addr);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({bus_de, rsp_valid} !== 2'b00) begin
        n_fail++; $display("FAIL midrst_quiet[%0d]: de/v %b exp 00", i, {bus_de, rsp_valid});
      end
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_ready: got %b exp 1", cmd_ready);
    end
    issue(1'b1, 32'hC, 32'h77, 8'd0);
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if ({bus_de, bus_rw} !== 2'b11 || bus_addr !== 32'hC || bus_wdata !== 32'h77) begin
      n_fail++;
      $display("FAIL midrst_new_access: de/rw %b addr %h wdata %h",
               {bus_de, bus_rw}, bus_addr, bus_wdata);
    end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_last} !== 2'b11 || rsp_rdata !== 32'h0 || mem[3] !== 32'h77) begin
      n_fail++;
      $display("FAIL midrst_new_resp: v/l %b rdata %h mem %h exp 11 0 77",
               {rsp_valid, rsp_last}, rsp_rdata, mem[3]);
    end
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_new_done: rdy %b exp 1", cmd_ready);
    end
  endtask

  initial begin
    mem[0] = 32'h0000FF00;
    mem[1] = 32'h0;
    mem[2] = 32'h0;
    mem[3] = 32'h22;
    test_reset();
    test_write();
    test_read();
    test_backpressure();
`ifdef MOD_BUS_MASTER_BURST_EN
    test_burst();
`else
    test_len_ignored();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
